// File: rtl/regfile_pkg.sv
// Shared constants, arbiter state type and a reference round-robin pick
// for the register-file write-port arbiter.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef enum logic [0:0] {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // Behavioural round-robin pick over up to 8 requesters.
   function automatic rr_pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                        input int numReq);
      rr_pick_t res;
      int       i;
      res = {1'b0, 3'd0};
      for (int k = numReq - 1; k >= 0; k--) begin
         i = (int'(ptr) + k) % numReq;
         if (valid[i]) begin
            res.found = 1'b1;
            res.idx   = 3'(i);
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: rotate by the pointer, take the lowest set
// bit, then rotate the index back into requester numbering.
module rr_priority_pick
   import regfile_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] winner,
   output logic          found
);

   localparam logic [IW:0] NUM = (IW + 1)'(N);

   logic [2*N-1:0] dbl_s;
   logic [N-1:0]   rot_s;
   logic [IW-1:0]  off_s;
   logic [IW:0]    sum_s;

   // Rotate, priority-encode, rotate back.
   always_comb begin
      dbl_s = {valid, valid} >> ptr;
      rot_s = dbl_s[N-1:0];
      off_s = {IW{1'b0}};
      for (int k = N - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            off_s = IW'(k);
         end else begin
            off_s = off_s;
         end
      end
      found = |rot_s;
      sum_s = {1'b0, ptr} + {1'b0, off_s};
      if (sum_s >= NUM) begin
         winner = IW'(sum_s - NUM);
      end else begin
         winner = sum_s[IW-1:0];
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing the register file write
// port. Optional per-requester statistics under REGFILE_ARB_STATS_EN.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4,
   parameter int IW        = $clog2(NUM_REQ)
) (
   input  logic                             clock,
   input  logic                             ctrl_reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_lock,
   input  logic [REG_ADDR_W*NUM_REQ-1:0]    req_reg,
   input  logic [REG_DATA_W*NUM_REQ-1:0]    req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic                             ctrl_writeEnable,
   output logic [REG_ADDR_W-1:0]            ctrl_writeReg,
   output logic [REG_DATA_W-1:0]            data_writeReg,
   output logic [IW-1:0]                    grant_id
`ifdef REGFILE_ARB_STATS_EN
   ,
   output logic [16*NUM_REQ-1:0]            grant_count,
   output logic [15:0]                      zero_drop_count
`endif
);

   localparam logic [3:0]         BURST_MAX = 4'(MAX_BURST);
   localparam logic               LOCK_EN   = (MAX_BURST > 1);
   localparam logic [IW-1:0]      LAST_ID   = IW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ - 1){1'b0}}, 1'b1};

   arb_state_t            state_r, state_s;
   logic [IW-1:0]         rrPtr_r, rrPtr_s, owner_r, owner_s;
   logic [IW-1:0]         pickId_s, winId_s, winNext_s;
   logic [3:0]            lockCnt_r, lockCnt_s;
   logic                  pickFound_s, xfer_s;
   logic [NUM_REQ-1:0]    grant_s;
   logic [REG_ADDR_W-1:0] winReg_s;
   logic [REG_DATA_W-1:0] winData_s;

   rr_priority_pick #(.N(NUM_REQ), .IW(IW)) uPick (
      .valid  (req_valid),
      .ptr    (rrPtr_r),
      .winner (pickId_s),
      .found  (pickFound_s)
   );

   // Grant decode; reset masks ready so nothing is accepted while held in reset.
   always_comb begin
      winId_s = (state_r == LOCK) ? owner_r : pickId_s;
      grant_s = {NUM_REQ{1'b0}};
      if (ctrl_reset) begin
         grant_s = {NUM_REQ{1'b0}};
      end else if (state_r == LOCK) begin
         if (req_valid[owner_r]) grant_s = ONE_HOT0 << owner_r;
         else                    grant_s = {NUM_REQ{1'b0}};
      end else begin
         if (pickFound_s) grant_s = ONE_HOT0 << pickId_s;
         else             grant_s = {NUM_REQ{1'b0}};
      end
      xfer_s    = |grant_s;
      winNext_s = (winId_s == LAST_ID) ? {IW{1'b0}} : winId_s + IW'(1);
      winReg_s  = req_reg[REG_ADDR_W*winId_s +: REG_ADDR_W];
      winData_s = req_data[REG_DATA_W*winId_s +: REG_DATA_W];
   end

   assign req_ready = grant_s;

   // Next-state logic for ARB/LOCK, pointer and burst counter.
   always_comb begin
      state_s   = state_r;
      rrPtr_s   = rrPtr_r;
      owner_s   = owner_r;
      lockCnt_s = lockCnt_r;
      case (state_r)
         ARB: begin
            if (xfer_s) begin
               rrPtr_s = winNext_s;
               if (req_lock[winId_s] && LOCK_EN) begin
                  state_s   = LOCK;
                  owner_s   = winId_s;
                  lockCnt_s = 4'd1;
               end else begin
                  state_s = ARB;
               end
            end else begin
               state_s = ARB;
            end
         end
         LOCK: begin
            // rrPtr already sits at owner+1, leaving the owner last on exit.
            if (xfer_s) lockCnt_s = lockCnt_r + 4'd1;
            else        lockCnt_s = lockCnt_r;
            if (!req_valid[owner_r] || !req_lock[owner_r] || (xfer_s && lockCnt_s == BURST_MAX)) begin
               state_s   = ARB;
               lockCnt_s = 4'd0;
            end else begin
               state_s = LOCK;
            end
         end
         default: begin
            state_s   = ARB;
            lockCnt_s = 4'd0;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         state_r   <= ARB;
         rrPtr_r   <= {IW{1'b0}};
         owner_r   <= {IW{1'b0}};
         lockCnt_r <= 4'd0;
      end else begin
         state_r   <= state_s;
         rrPtr_r   <= rrPtr_s;
         owner_r   <= owner_s;
         lockCnt_r <= lockCnt_s;
      end
   end

   // Register-file output stage; register-0 writes are accepted but not strobed.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= {REG_ADDR_W{1'b0}};
         data_writeReg    <= {REG_DATA_W{1'b0}};
         grant_id         <= {IW{1'b0}};
      end else if (xfer_s) begin
         ctrl_writeEnable <= (winReg_s != 5'd0);
         ctrl_writeReg    <= winReg_s;
         data_writeReg    <= winData_s;
         grant_id         <= winId_s;
      end else begin
         ctrl_writeEnable <= 1'b0;
      end
   end

`ifdef REGFILE_ARB_STATS_EN
   for (genvar g = 0; g < NUM_REQ; g++) begin : gStats
      // Saturating per-requester transfer counter.
      always_ff @(posedge clock or posedge ctrl_reset) begin
         if (ctrl_reset) begin
            grant_count[16*g +: 16] <= 16'd0;
         end else if (grant_s[g] && grant_count[16*g +: 16] != 16'hFFFF) begin
            grant_count[16*g +: 16] <= grant_count[16*g +: 16] + 16'd1;
         end else begin
            grant_count[16*g +: 16] <= grant_count[16*g +: 16];
         end
      end
   end

   // Saturating count of accepted register-0 writes.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         zero_drop_count <= 16'd0;
      end else if (xfer_s && winReg_s == 5'd0 && zero_drop_count != 16'hFFFF) begin
         zero_drop_count <= zero_drop_count + 16'd1;
      end else begin
         zero_drop_count <= zero_drop_count;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random checks of regfile_write_arbiter against a queue-free
// behavioural model of the round-robin / burst-lock rules.
module tb_regfile_write_arbiter;

   localparam int N  = 4;
   localparam int MB = 4;

   logic            clock = 1'b0;
   logic            ctrl_reset = 1'b1;
   logic [N-1:0]    req_valid = '0, req_lock = '0, req_ready;
   logic [5*N-1:0]  req_reg = '0;
   logic [32*N-1:0] req_data = '0;
   logic            ctrl_writeEnable;
   logic [4:0]      ctrl_writeReg;
   logic [31:0]     data_writeReg;
   logic [1:0]      grant_id;
`ifdef REGFILE_ARB_STATS_EN
   logic [16*N-1:0] grant_count;
   logic [15:0]     zero_drop_count;
`endif

   regfile_write_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
      .clock(clock), .ctrl_reset(ctrl_reset),
      .req_valid(req_valid), .req_lock(req_lock), .req_reg(req_reg), .req_data(req_data),
      .req_ready(req_ready), .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .grant_id(grant_id)
`ifdef REGFILE_ARB_STATS_EN
      , .grant_count(grant_count), .zero_drop_count(zero_drop_count)
`endif
   );

   always #5 clock = ~clock;

   int nChecks = 0;
   int nErr = 0;

   // model state
   int mPtr, mOwner, mCnt, mZero, lastW;
   bit mLocked;
   logic expWe;
   logic [4:0] expReg;
   logic [31:0] expData;
   logic [1:0] expGid;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int modelPick(input logic [N-1:0] v);
      int i;
      if (mLocked) return v[mOwner] ? mOwner : -1;
      for (int k = 0; k < N; k++) begin
         i = (mPtr + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic modelReset();
      mPtr = 0; mOwner = 0; mCnt = 0; mLocked = 0; mZero = 0; lastW = -1;
      expWe = 1'b0; expReg = 5'd0; expData = 32'd0; expGid = 2'd0;
   endtask

   task automatic doRst();
      ctrl_reset = 1'b1;
      #1;
      modelReset();
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_we", ctrl_writeEnable, 1'b0);
      chk("rst_reg", ctrl_writeReg, 5'd0);
      chk("rst_data", data_writeReg, 32'd0);
      chk("rst_gid", grant_id, 2'd0);
      @(posedge clock); #1;
      ctrl_reset = 1'b0;
   endtask

   task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic [5*N-1:0] r, input logic [32*N-1:0] d);
      int w;
      logic [N-1:0] expReady;
      req_valid = v; req_lock = l; req_reg = r; req_data = d;
      #1;
      w = modelPick(v);
      expReady = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk("req_ready", req_ready, expReady);
      if (w >= 0) begin
         expReg  = r[5*w +: 5];
         expData = d[32*w +: 32];
         expWe   = (expReg != 5'd0);
         expGid  = 2'(w);
         if (expReg == 5'd0) mZero++;
      end else begin
         expWe = 1'b0;
      end
      if (!mLocked) begin
         if (w >= 0) begin
            mPtr = (w + 1) % N;
            if (l[w] && MB > 1) begin mLocked = 1; mOwner = w; mCnt = 1; end
         end
      end else begin
         if (w >= 0) mCnt++;
         if (!v[mOwner] || !l[mOwner] || mCnt == MB) mLocked = 0;
      end
      lastW = w;
      @(posedge clock); #1;
      chk("we", ctrl_writeEnable, expWe);
      chk("wreg", ctrl_writeReg, expReg);
      chk("wdata", data_writeReg, expData);
      chk("gid", grant_id, expGid);
`ifdef REGFILE_ARB_STATS_EN
      chk("zero_cnt", zero_drop_count, 64'(mZero));
`endif
   endtask

   logic [5*N-1:0]  allRegs = {5'd13, 5'd12, 5'd11, 5'd10};
   logic [32*N-1:0] allData = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
   logic [N-1:0]    curV, curL;
   logic [5*N-1:0]  curR;
   logic [32*N-1:0] curD;

   initial begin
      doRst();

      // single requester 2
      step(4'b0100, 4'b0000, {5'd0, 5'd7, 5'd0, 5'd0}, {32'd0, 32'hDEADBEEF, 64'd0});
      chk("single_we", ctrl_writeEnable, 1'b1);
      chk("single_data", data_writeReg, 32'hDEADBEEF);
      chk("single_gid", grant_id, 2'd2);

      // all four valid, no lock, from reset
      doRst();
      for (int k = 0; k < 6; k++) begin
         step(4'b1111, 4'b0000, allRegs, allData);
         chk("rr_gid", grant_id, 64'(k % 4));
      end

      // requester 1 locked burst with requester 3 waiting
      doRst();
      for (int k = 0; k < 5; k++) step(4'b1010, 4'b0010, allRegs, allData);
      chk("after_burst_gid", grant_id, 2'd3);
      step(4'b0011, 4'b0000, allRegs, allData);
      chk("zero_before_one", grant_id, 2'd0);

      // lock dropped after two transfers
      doRst();
      step(4'b0010, 4'b0010, allRegs, allData);
      step(4'b0010, 4'b0000, allRegs, allData);
      step(4'b1111, 4'b0000, allRegs, allData);
      chk("post_lock_gid", grant_id, 2'd2);

      // write to register 0
      step(4'b0001, 4'b0000, {15'd0, 5'd0}, {96'd0, 32'h12345678});
      chk("zero_we", ctrl_writeEnable, 1'b0);
      chk("zero_data", data_writeReg, 32'h12345678);

      // reset mid-burst
      doRst();
      step(4'b0001, 4'b0001, allRegs, allData);
      step(4'b0001, 4'b0001, allRegs, allData);
      doRst();
      step(4'b1111, 4'b0000, allRegs, allData);
      chk("restart_gid", grant_id, 2'd0);

      // random traffic honouring hold-while-waiting
      curV = '0; curL = '0; curR = '0; curD = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (curV[i] && lastW != i && $urandom_range(0, 7) != 0) begin
               curV[i] = 1'b1;
            end else begin
               curV[i] = ($urandom_range(0, 9) < 7);
               curL[i] = ($urandom_range(0, 2) == 0);
               curR[5*i +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
               curD[32*i +: 32] = $urandom;
            end
         end
         step(curV, curL, curR, curD);
      end

      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end

endmodule
